// File: rtl/tile_pkg.sv
//------------------------------------------------------------------------------
// Module   : tile_pkg
// Brief    : Shared types, default geometry and sizing helpers for the
//            tile serializer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tile_pkg;

  // Default tile geometry
  localparam int DEF_ROWS   = 8;
  localparam int DEF_COLS   = 8;
  localparam int DEF_ELEM_W = 32;
  localparam int DEF_LANES  = 4;

  typedef logic [DEF_ELEM_W-1:0] elem_t;
  typedef elem_t [DEF_ROWS-1:0][DEF_COLS-1:0] tile_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Number of output beats needed to stream one tile
  function automatic int beats(input int rows, input int cols, input int lanes);
    return (rows * cols) / lanes;
  endfunction

  // Width of a beat index; never narrower than one bit
  function automatic int beat_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tile_serializer_if.sv
//------------------------------------------------------------------------------
// Module   : tile_serializer_if
// Brief    : Tile input handshake plus narrow beat output bus. The slave
//            modport is the serializer's view, master is its environment.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface tile_serializer_if
  import tile_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int ELEM_W = DEF_ELEM_W,
  parameter int LANES  = DEF_LANES
);

  localparam int BEATS  = beats(ROWS, COLS, LANES);
  localparam int BEAT_W = beat_w(BEATS);

  logic                                    in_valid;
  logic                                    in_ready;
  logic [ROWS-1:0][COLS-1:0][ELEM_W-1:0]   in_tile;
  logic                                    in_col_major;
  logic                                    out_valid;
  logic                                    out_ready;
  logic [LANES*ELEM_W-1:0]                 out_data;
  logic                                    out_first;
  logic                                    out_last;
  logic [BEAT_W-1:0]                       out_beat;

  modport master (
    output in_valid, in_tile, in_col_major, out_ready,
    input  in_ready, out_valid, out_data, out_first, out_last, out_beat
  );

  modport slave (
    input  in_valid, in_tile, in_col_major, out_ready,
    output in_ready, out_valid, out_data, out_first, out_last, out_beat
  );

endinterface

`default_nettype wire

// File: rtl/tile_beat_mux.sv
//------------------------------------------------------------------------------
// Module   : tile_beat_mux
// Brief    : Combinational beat selector. Every beat word is wired up from
//            constant element indices for both orderings, then the beat
//            counter picks one word - no run-time index arithmetic.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tile_beat_mux
  import tile_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int ELEM_W = DEF_ELEM_W,
  parameter int LANES  = DEF_LANES,
  parameter int BEATS  = beats(ROWS, COLS, LANES),
  parameter int BEAT_W = beat_w(BEATS)
) (
  input  wire logic [ROWS-1:0][COLS-1:0][ELEM_W-1:0] tile_i,
  input  wire logic [BEAT_W-1:0]                     beat_i,
  input  wire logic                                  col_major_i,
  output logic [LANES*ELEM_W-1:0]                    data_o
);

  // Power-of-two word count so every counter value selects a defined word
  localparam int NWORDS = 1 << BEAT_W;

  logic [NWORDS-1:0][LANES*ELEM_W-1:0] rm_words;
  logic [NWORDS-1:0][LANES*ELEM_W-1:0] cm_words;

  for (genvar b = 0; b < NWORDS; b++) begin : g_word
    if (b < BEATS) begin : g_live
      logic [LANES*ELEM_W-1:0] rm_w;
      logic [LANES*ELEM_W-1:0] cm_w;
      for (genvar l = 0; l < LANES; l++) begin : g_lane
        localparam int K = b * LANES + l;
        assign rm_w[l*ELEM_W +: ELEM_W] = tile_i[K / COLS][K % COLS];
        assign cm_w[l*ELEM_W +: ELEM_W] = tile_i[K % ROWS][K / ROWS];
      end
      assign rm_words[b] = rm_w;
      assign cm_words[b] = cm_w;
    end else begin : g_pad
      assign rm_words[b] = '0;
      assign cm_words[b] = '0;
    end
  end

  // Select the current beat in the ordering latched with the tile
  always_comb begin
    data_o = col_major_i ? cm_words[beat_i] : rm_words[beat_i];
  end

endmodule

`default_nettype wire

// File: rtl/tile_serializer.sv
//------------------------------------------------------------------------------
// Module   : tile_serializer
// Brief    : Accepts a whole ROWS x COLS tile, buffers it and streams it out
//            LANES elements per beat in row- or column-major order, with
//            zero-bubble back-to-back tile acceptance on the last beat.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tile_serializer
  import tile_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int ELEM_W = DEF_ELEM_W,
  parameter int LANES  = DEF_LANES
) (
  input  wire logic        clk,
  input  wire logic        reset,
  tile_serializer_if.slave bus
);

  localparam int                BEATS     = beats(ROWS, COLS, LANES);
  localparam int                BEAT_W    = beat_w(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  if ((ROWS * COLS) % LANES != 0) begin : g_chk_lanes
    $error("tile_serializer: ROWS*COLS must be divisible by LANES");
  end

  state_t                                state_q;
  logic [BEAT_W-1:0]                     beat_q;
  logic [ROWS-1:0][COLS-1:0][ELEM_W-1:0] buf_q;
  logic                                  col_major_q;

  logic on_last;

  assign on_last = (state_q == ST_SEND) && (beat_q == LAST_BEAT);

  // A new tile fits when idle, or when the final beat leaves this cycle
  assign bus.in_ready  = (state_q == ST_IDLE) || (on_last && bus.out_ready);
  assign bus.out_valid = (state_q == ST_SEND);
  assign bus.out_first = (state_q == ST_SEND) && (beat_q == '0);
  assign bus.out_last  = on_last;
  assign bus.out_beat  = beat_q;

  // Control FSM, beat counter and tile buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      buf_q       <= '0;
      col_major_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            buf_q       <= bus.in_tile;
            col_major_q <= bus.in_col_major;
            beat_q      <= '0;
            state_q     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (bus.out_ready) begin
            if (beat_q != LAST_BEAT) begin
              beat_q <= beat_q + 1'b1;
            end else if (bus.in_valid) begin
              // Reload on the last beat so the next tile follows with no gap
              buf_q       <= bus.in_tile;
              col_major_q <= bus.in_col_major;
              beat_q      <= '0;
            end else begin
              beat_q  <= '0;
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  tile_beat_mux #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .ELEM_W (ELEM_W),
    .LANES  (LANES),
    .BEATS  (BEATS),
    .BEAT_W (BEAT_W)
  ) u_mux (
    .tile_i      (buf_q),
    .beat_i      (beat_q),
    .col_major_i (col_major_q),
    .data_o      (bus.out_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_tile_serializer.sv
//------------------------------------------------------------------------------
// Module   : tb_tile_serializer
// Brief    : Self-checking bench for tile_serializer: directed pattern tiles,
//            back-to-back, random backpressure, mid-tile reset, and a
//            single-beat geometry instance.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tile_serializer;
  import tile_pkg::*;

  localparam int R  = 8, C = 8, EW = 32, L = 4;
  localparam int NB = (R * C) / L;
  localparam int R2 = 4, C2 = 2, EW2 = 8, L2 = 8;

  typedef logic [R2-1:0][C2-1:0][EW2-1:0] tile_b_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tile_serializer_if #(.ROWS(R),  .COLS(C),  .ELEM_W(EW),  .LANES(L))  ifa ();
  tile_serializer_if #(.ROWS(R2), .COLS(C2), .ELEM_W(EW2), .LANES(L2)) ifb ();

  tile_serializer #(.ROWS(R), .COLS(C), .ELEM_W(EW), .LANES(L)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  tile_serializer #(.ROWS(R2), .COLS(C2), .ELEM_W(EW2), .LANES(L2)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: lane l of beat b holds flat element k = b*L + l, placed by
  // the ordering rule for the tile.
  function automatic logic [127:0] ref_beat(input tile_t t, input bit cm, input int b);
    logic [127:0] d;
    int k, r, c;
    d = '0;
    for (int l = 0; l < L; l++) begin
      k = b * L + l;
      if (cm) begin r = k % R; c = k / R; end
      else    begin r = k / C; c = k % C; end
      d[l*EW +: EW] = t[r][c];
    end
    return d;
  endfunction

  function automatic tile_t pat_tile(input int base);
    tile_t t;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        t[r][c] = 32'(base + r * 16 + c);
    return t;
  endfunction

  function automatic tile_t rand_tile();
    tile_t t;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        t[r][c] = $urandom;
    return t;
  endfunction

  typedef struct {
    logic [127:0] data;
    int           beat;
  } exp_beat_t;

  exp_beat_t exp_q[$];

  logic         prev_stall = 1'b0;
  logic [127:0] prev_data;
  logic [3:0]   prev_beat;

  // Scoreboard for the default instance, sampled mid-cycle
  always @(negedge clk) begin : mon
    int        rem;
    exp_beat_t e;
    if (reset) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      rem = exp_q.size();
      check_val("out_valid", 128'(ifa.out_valid), 128'(rem > 0));
      check_val("in_ready", 128'(ifa.in_ready),
                128'((rem == 0) || (rem == 1 && ifa.out_ready)));
      if (rem > 0 && ifa.out_valid) begin
        e = exp_q[0];
        check_val("out_data", ifa.out_data, e.data);
        check_val("out_beat", 128'(ifa.out_beat), 128'(e.beat));
        check_val("out_first", 128'(ifa.out_first), 128'(e.beat == 0));
        check_val("out_last", 128'(ifa.out_last), 128'(e.beat == NB - 1));
      end
      if (prev_stall) begin
        check_val("stall_data", ifa.out_data, prev_data);
        check_val("stall_beat", 128'(ifa.out_beat), 128'(prev_beat));
      end
      prev_stall = ifa.out_valid && !ifa.out_ready;
      prev_data  = ifa.out_data;
      prev_beat  = ifa.out_beat;
      if (ifa.out_valid && ifa.out_ready && rem > 0) exp_q.pop_front();
      if (ifa.in_valid && ifa.in_ready) begin
        for (int b = 0; b < NB; b++) begin
          e.data = ref_beat(ifa.in_tile, ifa.in_col_major, b);
          e.beat = b;
          exp_q.push_back(e);
        end
      end
    end
  end

  // Offer a tile from posedge+1 and hold it until accepted; returns at
  // posedge+1 of the accepting edge.
  task automatic send_tile(input tile_t t, input bit cm);
    bit acc;
    ifa.in_valid     = 1'b1;
    ifa.in_tile      = t;
    ifa.in_col_major = cm;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      acc = ifa.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        ifa.in_valid = 1'b0;
        return;
      end
    end
    check_val("send_timeout", 128'(1), 128'(0));
    ifa.in_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tile_t   t;
    tile_b_t tb;
    int      nvalid;
    int      sent;
    bit      acc;
    bit      found;

    ifa.in_valid = 1'b0; ifa.in_tile = '0; ifa.in_col_major = 1'b0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.in_tile = '0; ifb.in_col_major = 1'b0; ifb.out_ready = 1'b1;

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_val("rst_valid", 128'(ifa.out_valid), 128'(0));
    check_val("rst_beat", 128'(ifa.out_beat), 128'(0));
    check_val("rst_first", 128'(ifa.out_first), 128'(0));
    check_val("rst_last", 128'(ifa.out_last), 128'(0));
    check_val("rst_data", ifa.out_data, 128'(0));
    check_val("rst_in_ready", 128'(ifa.in_ready), 128'(1));

    // Row-major pattern tile at full rate
    @(posedge clk); #1;
    send_tile(pat_tile(0), 1'b0);
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check_val("rm_b0", ifa.out_data, 128'h00000003_00000002_00000001_00000000);
        check_val("rm_b0_first", 128'(ifa.out_first), 128'(1));
      end
      if (i == NB - 1) begin
        check_val("rm_b15", ifa.out_data, 128'h00000077_00000076_00000075_00000074);
        check_val("rm_b15_last", 128'(ifa.out_last), 128'(1));
        check_val("rm_b15_beat", 128'(ifa.out_beat), 128'(15));
      end
    end

    // Column-major, same tile
    @(posedge clk); #1;
    send_tile(pat_tile(0), 1'b1);
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      if (i == 0)  check_val("cm_b0", ifa.out_data, 128'h00000030_00000020_00000010_00000000);
      if (i == 2)  check_val("cm_b2", ifa.out_data, 128'h00000031_00000021_00000011_00000001);
      if (i == 15) check_val("cm_b15", ifa.out_data, 128'h00000077_00000067_00000057_00000047);
    end

    // Back-to-back: A then B with in_valid held
    @(posedge clk); #1;
    ifa.in_valid = 1'b1; ifa.in_tile = pat_tile(0); ifa.in_col_major = 1'b0;
    @(negedge clk);
    check_val("b2b_idle_ready", 128'(ifa.in_ready), 128'(1));
    @(posedge clk); #1;
    ifa.in_tile = pat_tile(32'h100);
    nvalid = 0;
    for (int i = 0; i < 2 * NB; i++) begin
      @(negedge clk);
      if (ifa.out_valid) nvalid++;
      if (i == NB - 1) begin
        check_val("b2b_last_ready", 128'(ifa.in_ready), 128'(1));
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
      end
      if (i == NB) begin
        check_val("b2b_B0", ifa.out_data, 128'h00000103_00000102_00000101_00000100);
        check_val("b2b_B0_first", 128'(ifa.out_first), 128'(1));
      end
    end
    check_val("b2b_count", 128'(nvalid), 128'(2 * NB));

    // Random tiles under random backpressure
    @(posedge clk); #1;
    sent = 0;
    for (int cyc = 0; cyc < 700; cyc++) begin
      if (!ifa.in_valid) begin
        ifa.in_tile      = rand_tile();
        ifa.in_col_major = 1'($urandom_range(0, 1));
        if (sent < 12 && $urandom_range(0, 3) == 0) ifa.in_valid = 1'b1;
      end
      ifa.out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      acc = ifa.in_valid && ifa.in_ready;
      @(posedge clk); #1;
      if (acc) begin
        ifa.in_valid = 1'b0;
        sent++;
      end
    end
    ifa.in_valid  = 1'b0;
    ifa.out_ready = 1'b1;
    repeat (2 * NB + 4) @(posedge clk);
    #1;
    check_val("rand_drain", 128'(exp_q.size()), 128'(0));

    // Reset in the middle of a tile
    send_tile(pat_tile(0), 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ifa.out_valid && ifa.out_beat == 4'd7) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check_val("reach_beat7", 128'(found), 128'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("mrst_valid", 128'(ifa.out_valid), 128'(0));
    check_val("mrst_beat", 128'(ifa.out_beat), 128'(0));
    check_val("mrst_in_ready", 128'(ifa.in_ready), 128'(1));
    check_val("mrst_data", ifa.out_data, 128'(0));
    check_val("mrst_last", 128'(ifa.out_last), 128'(0));
    @(posedge clk); #1;
    t = rand_tile();
    send_tile(t, 1'b1);
    @(negedge clk);
    check_val("post_rst_b0", ifa.out_data, ref_beat(t, 1'b1, 0));
    check_val("post_rst_beat", 128'(ifa.out_beat), 128'(0));
    check_val("post_rst_first", 128'(ifa.out_first), 128'(1));
    repeat (NB + 2) @(posedge clk);
    #1;

    // Single-beat geometry: 4x2 tile of bytes, 8 lanes
    for (int r = 0; r < R2; r++)
      for (int c = 0; c < C2; c++)
        tb[r][c] = 8'(r * 16 + c);
    ifb.out_ready = 1'b0;
    ifb.in_valid = 1'b1; ifb.in_tile = tb; ifb.in_col_major = 1'b0;
    @(posedge clk); #1;
    ifb.in_valid = 1'b0;
    @(negedge clk);
    check_val("sw_rm_data", 128'(ifb.out_data), 128'(64'h31302120_11100100));
    check_val("sw_valid", 128'(ifb.out_valid), 128'(1));
    check_val("sw_first", 128'(ifb.out_first), 128'(1));
    check_val("sw_last", 128'(ifb.out_last), 128'(1));
    check_val("sw_beat", 128'(ifb.out_beat), 128'(0));
    check_val("sw_stall_ready", 128'(ifb.in_ready), 128'(0));
    @(posedge clk); #1;
    check_val("sw_stall_hold", 128'(ifb.out_data), 128'(64'h31302120_11100100));
    ifb.out_ready = 1'b1;
    ifb.in_valid = 1'b1; ifb.in_col_major = 1'b1;
    @(negedge clk);
    check_val("sw_b2b_ready", 128'(ifb.in_ready), 128'(1));
    @(posedge clk); #1;
    ifb.in_valid = 1'b0;
    @(negedge clk);
    check_val("sw_cm_data", 128'(ifb.out_data), 128'(64'h31211101_30201000));
    check_val("sw_cm_first_last", 128'({ifb.out_first, ifb.out_last}), 128'(2'b11));
    @(posedge clk); #1;
    @(negedge clk);
    check_val("sw_done_valid", 128'(ifb.out_valid), 128'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tile_serializer.md
Name: tile_serializer

Overview:
Parametrised successor to the fixed 8x8x32 flattener. Accepts a whole ROWS x COLS tile of ELEM_W-bit elements with a valid/ready handshake, holds it in a register buffer, and streams it out as LANES elements per beat over a narrow bus. Supports row-major or column-major (transposed) ordering per tile. Sits between the 2-D block compute stages and the narrow output/DMA path.

Parameters:
ROWS, 8, tile rows
COLS, 8, tile columns
ELEM_W, 32, element width in bits
LANES, 4, elements per output beat; ROWS*COLS must be divisible by LANES (elaboration-time assertion)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  tile offered
in_ready  out  1  tile accepted when in_valid && in_ready
in_tile  in  [ROWS][COLS][ELEM_W] packed  tile; [r][c] is row r, column c
in_col_major  in  1  ordering for this tile, sampled with the tile
out_valid  out  1  beat valid
out_ready  in  1  beat consumed when out_valid && out_ready
out_data  out  LANES*ELEM_W  beat; lane 0 in LSBs
out_first  out  1  high on beat 0 of a tile
out_last  out  1  high on final beat of a tile
out_beat  out  clog2(BEATS) (min 1)  index of current beat

Behaviour:
- BEATS = ROWS*COLS/LANES. Flat index k = beat*LANES + lane.
- Row-major: r = k / COLS, c = k % COLS. Column-major: r = k % ROWS, c = k / ROWS. Lane L of out_data = element at k = beat*LANES + L.
- States: IDLE, SEND.
- IDLE: in_ready=1, out_valid=0. On in_valid: latch in_tile and in_col_major, beat counter <= 0, go SEND.
- SEND: out_valid=1; out_data, out_first, out_last, out_beat driven combinationally from buffer and counter (registered state, no combinational path from in_* to out_*). On out_ready: if beat != BEATS-1 then beat++; else tile done.
- Back-to-back: in_ready = IDLE || (SEND && out_last && out_ready). If a new tile is accepted in the cycle the last beat is consumed, reload buffer, beat <= 0, stay in SEND; no bubble. Otherwise return to IDLE.
- Latency: tile accepted in cycle N -> beat 0 presented with out_valid in cycle N+1. Full tile at full rate takes BEATS cycles.
- Stall: out_ready=0 holds out_data, out_beat, out_first, out_last, and the buffer stable. out_valid never drops once raised until its beat is consumed.
- in_tile and in_col_major changes while in SEND are ignored unless accepted via the handshake.
- BEATS=1: out_first and out_last both high on the single beat.
- Reset (any state, including mid-tile): state IDLE, beat 0, out_valid 0, out_first 0, out_last 0, out_beat 0, out_data 0, buffer cleared; partial tile discarded; in_ready 1 from the cycle after reset deasserts.
- Counter arithmetic is unsigned. It never exceeds BEATS-1. Index math is on constants/counter only, with no multipliers beyond the elaboration-time ones.

Decomposition:
- Package tile_pkg: ROWS/COLS/ELEM_W defaults, elem_t typedef, tile_t typedef (packed [ROWS][COLS] elem_t), and a function beats(rows, cols, lanes).
- One sub-module: tile_beat_mux. It is combinational and maps buffer + beat + col_major to out_data. It is instantiated once.
- FSM, counter, and buffer live in the top.

Test Plan:
- Row-major, defaults, element[r][c] = r*16+c, out_ready=1 -> 16 beats. Beat 0 lanes 0..3 = 0x00,0x01,0x02,0x03 with out_first=1. Beat 15 = 0x74,0x75,0x76,0x77 with out_last=1, out_beat=15.
- Column-major, same tile -> beat 0 = 0x00,0x10,0x20,0x30. Beat 2 = 0x01,0x11,0x21,0x31. Beat 15 = 0x47,0x57,0x67,0x77.
- Back-to-back: tile A then tile B (element = 0x100+r*16+c) with in_valid held -> B beat 0 (0x100..0x103) appears in the cycle after A's last beat; 32 consecutive valid beats; in_ready high only on the A-last cycle.
- Backpressure: toggle out_ready pseudo-randomly -> out_data stable while stalled; beat order and count match the reference model; in_ready=0 throughout SEND until the last beat.
- Reset at beat 7 -> next cycle out_valid=0, out_beat=0, in_ready=1. The next tile starts cleanly at beat 0 with no residue of the old tile.
- Parameter sweep ROWS=4, COLS=2, ELEM_W=8, LANES=8 -> BEATS=1, out_first=out_last=1. Row-major data = elements [0][0],[0][1],[1][0],...,[3][1] from lane 0 up.
